// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Receive-side byte FIFO between the asynchronous receiver and the APB
//   register block. Bytes are captured on the receiver's active-low write
//   strobe. They are held in first-word-fall-through order, so the head
//   entry is always visible on rx_data. The block reports occupancy,
//   full/empty status and a sticky overflow flag.
//
//   Build option: define UART_RX_FIFO_PARITY_TAG_EN to store the receiver
//   parity flag with each byte and expose it on rx_data_parity_err.
//
// Ports
//   clk                 system clock, rising edge
//   reset_n             asynchronous active-low reset
//   fifo_write          active-low write strobe, one write per low cycle
//   rx_byte[7:0]        byte to store
//   parity_err          parity flag stored with the byte (option only)
//   read_rx_byte        one-cycle pop pulse
//   flush               synchronous clear of pointers, count and overflow
//   rx_data[7:0]        head entry, 8'h00 when empty
//   rx_data_parity_err  parity flag of head entry (option only), 0 when empty
//   receive_full        FIFO non-empty
//   fifo_full           occupancy equals depth
//   fifo_count          occupancy, 0..depth
//   overflow            sticky, set when a write is dropped
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  fifo_write,
    input  logic [7:0]            rx_byte,
    input  logic                  parity_err,
    input  logic                  read_rx_byte,
    input  logic                  flush,
    output logic [7:0]            rx_data,
`ifdef UART_RX_FIFO_PARITY_TAG_EN
    output logic                  rx_data_parity_err,
`endif
    output logic                  receive_full,
    output logic                  fifo_full,
    output logic [DEPTH_LOG2:0]   fifo_count,
    output logic                  overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

`ifdef UART_RX_FIFO_PARITY_TAG_EN
    localparam int ENTRY_W = 9;
`else
    localparam int ENTRY_W = 8;
`endif

    logic [ENTRY_W-1:0]    mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  overflow_q;

    logic                  empty;
    logic                  full;
    logic                  wr_req;
    logic                  pop;
    logic                  wr_en;
    logic                  drop;
    logic [ENTRY_W-1:0]    wr_entry;
    logic [ENTRY_W-1:0]    head;

    assign empty  = (count == '0);
    assign full   = (count == DEPTH_CNT);
    assign wr_req = ~fifo_write;
    // A pop on an empty FIFO is ignored outright.
    assign pop    = read_rx_byte & ~empty;
    // When full, a same-cycle pop frees the slot the new byte lands in.
    assign wr_en  = wr_req & (~full | pop);
    assign drop   = wr_req & full & ~pop;

`ifdef UART_RX_FIFO_PARITY_TAG_EN
    assign wr_entry = {parity_err, rx_byte};
`else
    logic unused_parity_err;
    assign unused_parity_err = parity_err;
    assign wr_entry = rx_byte;
`endif

    // Storage array: data only, no reset. Flush leaves contents in place
    // but blocks the same-cycle write so the pointers stay consistent.
    always_ff @(posedge clk) begin
        if (wr_en && !flush) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            // Simultaneous write and pop leaves the count unchanged.
            case ({wr_en, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            // A dropped write wins over a same-cycle clearing read.
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (read_rx_byte) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign head         = mem[rd_ptr];
    assign rx_data      = empty ? 8'h00 : head[7:0];
`ifdef UART_RX_FIFO_PARITY_TAG_EN
    assign rx_data_parity_err = empty ? 1'b0 : head[8];
`endif
    assign receive_full = ~empty;
    assign fifo_full    = full;
    assign fifo_count   = count;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed testbench for uart_rx_fifo with DEPTH_LOG2=4 (depth 16).
module tb_uart_rx_fifo;

    logic       clk;
    logic       reset_n;
    logic       fifo_write;
    logic [7:0] rx_byte;
    logic       parity_err;
    logic       read_rx_byte;
    logic       flush;
    logic [7:0] rx_data;
    logic       receive_full;
    logic       fifo_full;
    logic [4:0] fifo_count;
    logic       overflow;
`ifdef UART_RX_FIFO_PARITY_TAG_EN
    logic       rx_data_parity_err;
`endif

    int checks = 0;
    int errors = 0;

    uart_rx_fifo #(.DEPTH_LOG2(4)) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .fifo_write         (fifo_write),
        .rx_byte            (rx_byte),
        .parity_err         (parity_err),
        .read_rx_byte       (read_rx_byte),
        .flush              (flush),
        .rx_data            (rx_data),
`ifdef UART_RX_FIFO_PARITY_TAG_EN
        .rx_data_parity_err (rx_data_parity_err),
`endif
        .receive_full       (receive_full),
        .fifo_full          (fifo_full),
        .fifo_count         (fifo_count),
        .overflow           (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock cycle of stimulus; returns 1 time unit after the rising edge.
    task automatic cyc(input logic w, input logic [7:0] b, input logic p,
                       input logic r, input logic f);
        fifo_write   = ~w;
        rx_byte      = b;
        parity_err   = p;
        read_rx_byte = r;
        flush        = f;
        @(posedge clk);
        #1;
        fifo_write   = 1'b1;
        read_rx_byte = 1'b0;
        flush        = 1'b0;
        parity_err   = 1'b0;
    endtask

    task automatic test_reset;
        checks++; if (receive_full !== 1'b0) begin errors++; $display("FAIL reset_receive_full: got %b exp 0", receive_full); end
        checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL reset_fifo_full: got %b exp 0", fifo_full); end
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", fifo_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b exp 0", overflow); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h exp 00", rx_data); end
    endtask

    task automatic test_single;
        cyc(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        checks++; if (receive_full !== 1'b1) begin errors++; $display("FAIL single_receive_full: got %b exp 1", receive_full); end
        checks++; if (fifo_count !== 5'd1) begin errors++; $display("FAIL single_count: got %0d exp 1", fifo_count); end
        checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL single_rx_data: got %h exp a5", rx_data); end
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        checks++; if (receive_full !== 1'b0) begin errors++; $display("FAIL single_pop_receive_full: got %b exp 0", receive_full); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL single_pop_rx_data: got %h exp 00", rx_data); end
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL single_pop_count: got %0d exp 0", fifo_count); end
    endtask

    task automatic test_fill_overflow;
        for (int i = 0; i < 16; i++) begin
            checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL fill_early_full: got %b exp 0 at %0d", fifo_full, i); end
            cyc(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        end
        checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL fill_full: got %b exp 1", fifo_full); end
        checks++; if (fifo_count !== 5'd16) begin errors++; $display("FAIL fill_count: got %0d exp 16", fifo_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_overflow_pre: got %b exp 0", overflow); end
        cyc(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL drop_overflow: got %b exp 1", overflow); end
        checks++; if (fifo_count !== 5'd16) begin errors++; $display("FAIL drop_count: got %0d exp 16", fifo_count); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL drop_head: got %h exp 00", rx_data); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (rx_data !== 8'(i)) begin errors++; $display("FAIL fill_pop_data: got %h exp %h", rx_data, 8'(i)); end
            cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
            if (i == 0) begin
                checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL pop_clears_overflow: got %b exp 0", overflow); end
                checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL pop_clears_full: got %b exp 0", fifo_full); end
            end
        end
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL fill_drain_count: got %0d exp 0", fifo_count); end
        checks++; if (receive_full !== 1'b0) begin errors++; $display("FAIL fill_drain_empty: got %b exp 0", receive_full); end
    endtask

    task automatic test_full_swap;
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
        checks++; if (fifo_count !== 5'd16) begin errors++; $display("FAIL swap_count: got %0d exp 16", fifo_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL swap_overflow: got %b exp 0", overflow); end
        checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL swap_full: got %b exp 1", fifo_full); end
        for (int i = 1; i < 16; i++) begin
            checks++; if (rx_data !== 8'h10 + 8'(i)) begin errors++; $display("FAIL swap_pop_data: got %h exp %h", rx_data, 8'h10 + 8'(i)); end
            cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        end
        checks++; if (rx_data !== 8'h55) begin errors++; $display("FAIL swap_last_data: got %h exp 55", rx_data); end
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL swap_drain_count: got %0d exp 0", fifo_count); end
    endtask

    task automatic test_empty_simul;
        cyc(1'b1, 8'h3C, 1'b0, 1'b1, 1'b0);
        checks++; if (fifo_count !== 5'd1) begin errors++; $display("FAIL empty_simul_count: got %0d exp 1", fifo_count); end
        checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL empty_simul_data: got %h exp 3c", rx_data); end
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL lone_pop_count: got %0d exp 0", fifo_count); end
        checks++; if (receive_full !== 1'b0) begin errors++; $display("FAIL lone_pop_receive_full: got %b exp 0", receive_full); end
        checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL lone_pop_full: got %b exp 0", fifo_full); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL lone_pop_overflow: got %b exp 0", overflow); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL lone_pop_data: got %h exp 00", rx_data); end
    endtask

    task automatic test_flush_wrap;
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0, 1'b0);
        checks++; if (fifo_count !== 5'd5) begin errors++; $display("FAIL flush_pre_count: got %0d exp 5", fifo_count); end
        cyc(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL flush_count: got %0d exp 0", fifo_count); end
        checks++; if (receive_full !== 1'b0) begin errors++; $display("FAIL flush_receive_full: got %b exp 0", receive_full); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL flush_overflow: got %b exp 0", overflow); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL flush_data: got %h exp 00", rx_data); end
        // Three entries in flight so data crosses the pointer wrap at depth 16.
        cyc(1'b1, 8'h80, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h81, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h82, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            checks++; if (rx_data !== 8'h80 + 8'(k)) begin errors++; $display("FAIL wrap_data: got %h exp %h", rx_data, 8'h80 + 8'(k)); end
            cyc(1'b1, 8'h83 + 8'(k), 1'b0, 1'b1, 1'b0);
        end
        checks++; if (fifo_count !== 5'd3) begin errors++; $display("FAIL wrap_count: got %0d exp 3", fifo_count); end
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_parity_tag;
`ifdef UART_RX_FIFO_PARITY_TAG_EN
        cyc(1'b1, 8'h12, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 8'h34, 1'b0, 1'b0, 1'b0);
        checks++; if (rx_data_parity_err !== 1'b1) begin errors++; $display("FAIL parity_head0: got %b exp 1", rx_data_parity_err); end
        checks++; if (rx_data !== 8'h12) begin errors++; $display("FAIL parity_data0: got %h exp 12", rx_data); end
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        checks++; if (rx_data_parity_err !== 1'b0) begin errors++; $display("FAIL parity_head1: got %b exp 0", rx_data_parity_err); end
        checks++; if (rx_data !== 8'h34) begin errors++; $display("FAIL parity_data1: got %h exp 34", rx_data); end
        cyc(1'b1, 8'h56, 1'b1, 1'b1, 1'b0);
        checks++; if (rx_data_parity_err !== 1'b1) begin errors++; $display("FAIL parity_head2: got %b exp 1", rx_data_parity_err); end
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checks++; if (rx_data_parity_err !== 1'b0) begin errors++; $display("FAIL parity_empty: got %b exp 0", rx_data_parity_err); end
`endif
    endtask

    task automatic test_async_reset;
        for (int i = 0; i < 17; i++) cyc(1'b1, 8'h60 + 8'(i), 1'b1, 1'b0, 1'b0);
        checks++; if (overflow !== 1'b1 || fifo_full !== 1'b1) begin errors++; $display("FAIL areset_setup: got ovf=%b full=%b exp 1 1", overflow, fifo_full); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (receive_full !== 1'b0) begin errors++; $display("FAIL areset_receive_full: got %b exp 0", receive_full); end
        checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL areset_fifo_full: got %b exp 0", fifo_full); end
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL areset_count: got %0d exp 0", fifo_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL areset_overflow: got %b exp 0", overflow); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL areset_rx_data: got %h exp 00", rx_data); end
`ifdef UART_RX_FIFO_PARITY_TAG_EN
        checks++; if (rx_data_parity_err !== 1'b0) begin errors++; $display("FAIL areset_parity: got %b exp 0", rx_data_parity_err); end
`endif
        #2;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        cyc(1'b1, 8'h9D, 1'b0, 1'b0, 1'b0);
        checks++; if (fifo_count !== 5'd1 || rx_data !== 8'h9D) begin errors++; $display("FAIL post_reset_write: got count=%0d data=%h exp 1 9d", fifo_count, rx_data); end
    endtask

    initial begin
        reset_n      = 1'b0;
        fifo_write   = 1'b1;
        rx_byte      = 8'h00;
        parity_err   = 1'b0;
        read_rx_byte = 1'b0;
        flush        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        test_single();
        test_fill_overflow();
        test_full_swap();
        test_empty_simul();
        test_flush_wrap();
        test_parity_tag();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
